// File: rtl/rvfi_pkg.sv
// Shared RVFI types: RV32 opcodes, fixed mode/ixl values and the per-channel
// decode record. Trap checking is enabled by defining RVFI_TRAP_CHECK_EN.
package rvfi_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [1:0] MODE_M = 2'b11;
  localparam logic [1:0] IXL_32 = 2'b01;

  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        trap;
  } lane_dec_t;

endpackage

// File: rtl/rvfi_channel.sv
// Per-channel decode: register field masking, memory masking and
// (with RVFI_TRAP_CHECK_EN) pc / access alignment trap detection.
module rvfi_channel
  import rvfi_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]       i_insn,
  input  logic [1:0]        i_new_pc_lo,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [XLEN-1:0]   i_mem_addr,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic [XLEN-1:0]   i_mem_wdata,
  input  logic [XLEN/8-1:0] i_mem_be,
  input  logic [XLEN-1:0]   i_rd_wdata,
  output lane_dec_t         o_dec,
  output logic [XLEN-1:0]   o_rd_wdata,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_rdata,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_rmask,
  output logic [XLEN/8-1:0] o_mem_wmask
);

`ifdef RVFI_TRAP_CHECK_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic            w_no_rs1;
  logic            w_has_rs2;
  logic            w_no_rd;
  logic            w_mis;
  logic            w_ld;
  logic            w_st;
  logic [XLEN-1:0] w_bmask;
  int              w_nb;

  // opcode classes that drop rs1 / rs2 / rd
  always_comb begin
    w_no_rs1  = 1'b0;
    w_has_rs2 = 1'b0;
    w_no_rd   = 1'b0;
    unique case (i_insn[6:0])
      LUI, AUIPC, JAL: w_no_rs1 = 1'b1;
      OP:              w_has_rs2 = 1'b1;
      STORE, BRANCH: begin
        w_has_rs2 = 1'b1;
        w_no_rd   = 1'b1;
      end
      OP_IMM, LOAD, JALR: w_no_rd = 1'b0;
      default:            w_no_rd = 1'b0;
    endcase
  end

  // byte-enable expansion and access-size alignment check
  always_comb begin
    w_nb    = 0;
    w_bmask = '0;
    for (int b = 0; b < XLEN/8; b++) begin
      w_bmask[b*8 +: 8] = {8{i_mem_be[b]}};
      if (i_mem_be[b]) w_nb = w_nb + 1;
    end
    w_mis = (w_nb >= 2 && i_mem_addr[0])
         || (w_nb >= 4 && i_mem_addr[1])
         || (w_nb >= 8 && i_mem_addr[2]);
  end

  // masked decode record and memory fields
  always_comb begin
    o_dec      = '0;
    o_dec.insn = i_insn;
    o_dec.trap = TRAP_EN
              && ((i_new_pc_lo != 2'b00) || (i_mem_req && w_mis));
    o_dec.rs1  = w_no_rs1 ? 5'd0 : i_insn[19:15];
    o_dec.rs2  = w_has_rs2 ? i_insn[24:20] : 5'd0;
    o_dec.rd   = (w_no_rd || o_dec.trap) ? 5'd0 : i_insn[11:7];
    o_rd_wdata = (o_dec.rd == 5'd0) ? '0 : i_rd_wdata;
    w_ld = i_mem_req && !i_mem_we && !o_dec.trap;
    w_st = i_mem_req && i_mem_we && !o_dec.trap;
    o_mem_addr  = i_mem_req ? i_mem_addr : '0;
    o_mem_rmask = w_ld ? i_mem_be : '0;
    o_mem_wmask = w_st ? i_mem_be : '0;
    o_mem_rdata = w_ld ? (i_mem_rdata & w_bmask) : '0;
    o_mem_wdata = w_st ? (i_mem_wdata & w_bmask) : '0;
  end

endmodule

// File: rtl/rvfi_multi_retire.sv
// Multi-retire RVFI tracer: intra-group forwarding, lane compaction,
// order counter, 1/2 cycle latency. Trap checks via RVFI_TRAP_CHECK_EN.
module rvfi_multi_retire
  import rvfi_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int ORDER_W = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NRET-1:0]        retire,
  input  logic [NRET*32-1:0]     instruction,
  input  logic [32*XLEN-1:0]     old_regfile,
  input  logic [NRET*XLEN-1:0]   rd_wdata_in,
  input  logic [NRET*XLEN-1:0]   old_pc,
  input  logic [NRET*XLEN-1:0]   new_pc,
  input  logic [NRET-1:0]        mem_req,
  input  logic [NRET-1:0]        mem_we,
  input  logic [NRET*XLEN-1:0]   mem_addr,
  input  logic [NRET*XLEN-1:0]   mem_rdata,
  input  logic [NRET*XLEN-1:0]   mem_wdata,
  input  logic [NRET*XLEN/8-1:0] mem_be,
  output logic [NRET-1:0]        rvfi_valid,
  output logic [NRET-1:0]        rvfi_trap,
  output logic [NRET-1:0]        rvfi_halt,
  output logic [NRET-1:0]        rvfi_intr,
  output logic [NRET*ORDER_W-1:0] rvfi_order,
  output logic [NRET*32-1:0]     rvfi_insn,
  output logic [NRET*2-1:0]      rvfi_mode,
  output logic [NRET*2-1:0]      rvfi_ixl,
  output logic [NRET*5-1:0]      rvfi_rs1_addr,
  output logic [NRET*5-1:0]      rvfi_rs2_addr,
  output logic [NRET*5-1:0]      rvfi_rd_addr,
  output logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  output logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  output logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
  output logic [NRET*XLEN/8-1:0] rvfi_mem_wmask
);

  localparam int B        = XLEN / 8;
  localparam int OFF_MWD  = 0;
  localparam int OFF_MRD  = XLEN;
  localparam int OFF_WM   = 2 * XLEN;
  localparam int OFF_RM   = 2 * XLEN + B;
  localparam int OFF_MA   = 2 * XLEN + 2 * B;
  localparam int OFF_PCW  = 3 * XLEN + 2 * B;
  localparam int OFF_PCR  = 4 * XLEN + 2 * B;
  localparam int OFF_RDW  = 5 * XLEN + 2 * B;
  localparam int OFF_RS2D = 6 * XLEN + 2 * B;
  localparam int OFF_RS1D = 7 * XLEN + 2 * B;
  localparam int OFF_RD   = 8 * XLEN + 2 * B;
  localparam int OFF_RS2  = OFF_RD + 5;
  localparam int OFF_RS1  = OFF_RD + 10;
  localparam int OFF_INSN = OFF_RD + 15;
  localparam int OFF_TRAP = OFF_INSN + 32;
  localparam int LW       = OFF_TRAP + 1;

  lane_dec_t        w_dec  [NRET];
  logic [XLEN-1:0]  w_rdw  [NRET];
  logic [XLEN-1:0]  w_ma   [NRET];
  logic [XLEN-1:0]  w_mrd  [NRET];
  logic [XLEN-1:0]  w_mwd  [NRET];
  logic [B-1:0]     w_rm   [NRET];
  logic [B-1:0]     w_wm   [NRET];
  logic [XLEN-1:0]  w_rs1d [NRET];
  logic [XLEN-1:0]  w_rs2d [NRET];
  logic [LW-1:0]    w_ch   [NRET];
  logic [LW-1:0]    w_cl   [NRET];
  logic [ORDER_W-1:0] w_co [NRET];
  logic [NRET-1:0]  w_cv;
  logic [ORDER_W-1:0] w_pop;

  logic [ORDER_W-1:0] r_order;
  logic [NRET-1:0]    r_v;
  logic [LW-1:0]      r_l [NRET];
  logic [ORDER_W-1:0] r_o [NRET];

  logic [NRET-1:0]    w_fv;
  logic [LW-1:0]      w_fl [NRET];
  logic [ORDER_W-1:0] w_fo [NRET];

  for (genvar k = 0; k < NRET; k++) begin : g_ch
    rvfi_channel #(.XLEN(XLEN)) u_ch (
      .i_insn      (instruction[k*32 +: 32]),
      .i_new_pc_lo (new_pc[k*XLEN +: 2]),
      .i_mem_req   (mem_req[k]),
      .i_mem_we    (mem_we[k]),
      .i_mem_addr  (mem_addr[k*XLEN +: XLEN]),
      .i_mem_rdata (mem_rdata[k*XLEN +: XLEN]),
      .i_mem_wdata (mem_wdata[k*XLEN +: XLEN]),
      .i_mem_be    (mem_be[k*B +: B]),
      .i_rd_wdata  (rd_wdata_in[k*XLEN +: XLEN]),
      .o_dec       (w_dec[k]),
      .o_rd_wdata  (w_rdw[k]),
      .o_mem_addr  (w_ma[k]),
      .o_mem_rdata (w_mrd[k]),
      .o_mem_wdata (w_mwd[k]),
      .o_mem_rmask (w_rm[k]),
      .o_mem_wmask (w_wm[k])
    );
    assign w_ch[k] = {w_dec[k].trap, w_dec[k].insn, w_dec[k].rs1,
                      w_dec[k].rs2, w_dec[k].rd, w_rs1d[k], w_rs2d[k],
                      w_rdw[k], old_pc[k*XLEN +: XLEN],
                      new_pc[k*XLEN +: XLEN], w_ma[k], w_rm[k], w_wm[k],
                      w_mrd[k], w_mwd[k]};
  end

  // source reads: latest earlier retiring writer wins over old regfile
  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      w_rs1d[k] = '0;
      w_rs2d[k] = '0;
      if (w_dec[k].rs1 != 5'd0)
        w_rs1d[k] = old_regfile[(31 - int'(w_dec[k].rs1))*XLEN +: XLEN];
      if (w_dec[k].rs2 != 5'd0)
        w_rs2d[k] = old_regfile[(31 - int'(w_dec[k].rs2))*XLEN +: XLEN];
      for (int j = 0; j < k; j++) begin
        if (retire[j] && w_dec[j].rd != 5'd0) begin
          if (w_dec[j].rd == w_dec[k].rs1)
            w_rs1d[k] = rd_wdata_in[j*XLEN +: XLEN];
          if (w_dec[j].rd == w_dec[k].rs2)
            w_rs2d[k] = rd_wdata_in[j*XLEN +: XLEN];
        end
      end
    end
  end

  // pack retiring channels into the low lanes and assign orders
  always_comb begin
    int n;
    n    = 0;
    w_cv = '0;
    for (int i = 0; i < NRET; i++) begin
      w_cl[i] = '0;
      w_co[i] = '0;
    end
    for (int k = 0; k < NRET; k++) begin
      if (retire[k]) begin
        w_cl[n] = w_ch[k];
        w_cv[n] = 1'b1;
        n = n + 1;
      end
    end
    for (int i = 0; i < NRET; i++)
      if (w_cv[i]) w_co[i] = r_order + ORDER_W'(i + 1);
    w_pop = ORDER_W'(n);
  end

  // first output stage and order counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_order <= '0;
      r_v     <= '0;
      for (int i = 0; i < NRET; i++) begin
        r_l[i] <= '0;
        r_o[i] <= '0;
      end
    end else begin
      r_order <= r_order + w_pop;
      r_v     <= w_cv;
      for (int i = 0; i < NRET; i++) begin
        r_l[i] <= w_cl[i];
        r_o[i] <= w_co[i];
      end
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [NRET-1:0]    r2_v;
    logic [LW-1:0]      r2_l [NRET];
    logic [ORDER_W-1:0] r2_o [NRET];

    // extra register copy, no stall path
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r2_v <= '0;
        for (int i = 0; i < NRET; i++) begin
          r2_l[i] <= '0;
          r2_o[i] <= '0;
        end
      end else begin
        r2_v <= r_v;
        for (int i = 0; i < NRET; i++) begin
          r2_l[i] <= r_l[i];
          r2_o[i] <= r_o[i];
        end
      end
    end

    assign w_fv = r2_v;
    assign w_fl = r2_l;
    assign w_fo = r2_o;
  end else begin : g_lat1
    assign w_fv = r_v;
    assign w_fl = r_l;
    assign w_fo = r_o;
  end

  assign rvfi_valid = w_fv;
  assign rvfi_halt  = '0;
  assign rvfi_intr  = '0;

  for (genvar i = 0; i < NRET; i++) begin : g_out
    assign rvfi_trap[i] = w_fl[i][OFF_TRAP];
    assign rvfi_order[i*ORDER_W +: ORDER_W] = w_fo[i];
    assign rvfi_insn[i*32 +: 32] = w_fl[i][OFF_INSN +: 32];
    assign rvfi_mode[i*2 +: 2] = w_fv[i] ? MODE_M : 2'b00;
    assign rvfi_ixl[i*2 +: 2]  = w_fv[i] ? IXL_32 : 2'b00;
    assign rvfi_rs1_addr[i*5 +: 5] = w_fl[i][OFF_RS1 +: 5];
    assign rvfi_rs2_addr[i*5 +: 5] = w_fl[i][OFF_RS2 +: 5];
    assign rvfi_rd_addr[i*5 +: 5]  = w_fl[i][OFF_RD +: 5];
    assign rvfi_rs1_rdata[i*XLEN +: XLEN] = w_fl[i][OFF_RS1D +: XLEN];
    assign rvfi_rs2_rdata[i*XLEN +: XLEN] = w_fl[i][OFF_RS2D +: XLEN];
    assign rvfi_rd_wdata[i*XLEN +: XLEN]  = w_fl[i][OFF_RDW +: XLEN];
    assign rvfi_pc_rdata[i*XLEN +: XLEN]  = w_fl[i][OFF_PCR +: XLEN];
    assign rvfi_pc_wdata[i*XLEN +: XLEN]  = w_fl[i][OFF_PCW +: XLEN];
    assign rvfi_mem_addr[i*XLEN +: XLEN]  = w_fl[i][OFF_MA +: XLEN];
    assign rvfi_mem_rdata[i*XLEN +: XLEN] = w_fl[i][OFF_MRD +: XLEN];
    assign rvfi_mem_wdata[i*XLEN +: XLEN] = w_fl[i][OFF_MWD +: XLEN];
    assign rvfi_mem_rmask[i*B +: B] = w_fl[i][OFF_RM +: B];
    assign rvfi_mem_wmask[i*B +: B] = w_fl[i][OFF_WM +: B];
  end

endmodule
